// File: rtl/rx_frame_pkg.sv
// rx_frame_pkg: shared types for the receive frame sequencer.
// Bank lifecycle, sequencer states and the queued frame descriptor.
package rx_frame_pkg;

  // Descriptor length field; sized to the default receiver index width.
  localparam int LEN_W = 14;

  typedef enum logic [1:0] {
    FREE,
    FILLING,
    QUEUED,
    HELD
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    COMMIT
  } fsm_t;

  typedef struct packed {
    logic             bank;
    logic [LEN_W-1:0] len;
    logic [7:0]       div;
  } desc_t;

endpackage

// File: rtl/rx_desc_fifo.sv
// rx_desc_fifo: two-entry descriptor queue with valid/ready on both sides.
// Push and pop in the same cycle both take effect.
module rx_desc_fifo
  import rx_frame_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  in_valid,
  output logic  in_ready,
  input  desc_t in_desc,
  output logic  out_valid,
  input  logic  out_ready,
  output desc_t out_desc
);

  desc_t      mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       push;
  logic       pop;

  assign in_ready  = count != 2'd2;
  assign out_valid = count != 2'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_desc  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_desc;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/rx_frame_ctrl.sv
// rx_frame_ctrl: steers receiver bytes into a ping-pong frame buffer.
// Queues finished frames, drops bad or unbuffered ones and counts them.
module rx_frame_ctrl
  import rx_frame_pkg::*;
#(
  parameter int AW      = 14,
  parameter int MAX_LEN = 4096,
  parameter int MIN_LEN = 1,
  parameter int CW      = 16
) (
  input  logic                       rxclk,
  input  logic                       rst,
  input  logic                       rx_active,
  input  logic [AW-1:0]              rx_addr,
  input  logic [7:0]                 rx_data,
  input  logic [7:0]                 rx_div,
  output logic                       wr_en,
  output logic                       wr_bank,
  output logic [$clog2(MAX_LEN)-1:0] wr_addr,
  output logic [7:0]                 wr_data,
  output logic                       frm_valid,
  input  logic                       frm_ready,
  output logic                       frm_bank,
  output logic [AW-1:0]              frm_len,
  output logic [7:0]                 frm_div,
  input  logic                       rel,
  input  logic                       rel_bank,
  output logic [CW-1:0]              drop_cnt,
  output logic [CW-1:0]              frm_cnt
);

  localparam int WAW = $clog2(MAX_LEN);
  localparam logic [AW-1:0] MAX_A = AW'(MAX_LEN);
  localparam logic [AW-1:0] MIN_A = AW'(MIN_LEN);

  fsm_t        state_q;
  fsm_t        state_d;
  bank_state_t bank_st [2];
  logic        last_bank;
  logic        cur_bank;
  logic        hdr_seen;
  logic        ovf;
  logic [AW-1:0] len;
  logic [7:0]  div_q;

  logic  free0;
  logic  free1;
  logic  take;
  logic  take_bank;
  logic  commit;
  logic  drop_inc;
  logic  proc;
  logic  hdr_in;
  logic  ovf_in;
  logic  do_wr;
  logic  keep;
  logic  push;
  logic  pop;
  logic  fifo_ready;
  desc_t in_desc;
  desc_t head;

  assign free0 = bank_st[0] == FREE;
  assign free1 = bank_st[1] == FREE;

  always_comb begin
    state_d   = state_q;
    take      = 1'b0;
    take_bank = ~last_bank;
    commit    = 1'b0;
    drop_inc  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_active) begin
          if (free0 || free1) begin
            take      = 1'b1;
            take_bank = (free0 && free1) ? ~last_bank : free1;
            state_d   = RECV;
          end else begin
            state_d = DROP;
          end
        end
      end
      RECV: if (!rx_active) state_d = COMMIT;
      DROP: begin
        if (!rx_active) begin
          drop_inc = 1'b1;
          state_d  = IDLE;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The bank-claiming cycle already carries the first receiver sample.
  assign proc   = (state_q == RECV) || take;
  assign hdr_in = hdr_seen && !take;
  assign ovf_in = ovf && !take;
  assign do_wr  = proc && hdr_in && !ovf_in
                  && rx_addr != '0 && rx_addr <= MAX_A;

  assign keep    = !ovf && hdr_seen && len >= MIN_A && fifo_ready;
  assign push    = commit && keep;
  assign pop     = frm_valid && frm_ready;
  assign in_desc = '{bank: cur_bank, len: LEN_W'(len), div: div_q};

  always_ff @(posedge rxclk) begin
    if (rst) begin
      state_q    <= IDLE;
      bank_st[0] <= FREE;
      bank_st[1] <= FREE;
      last_bank  <= 1'b1;
      cur_bank   <= 1'b0;
      hdr_seen   <= 1'b0;
      ovf        <= 1'b0;
      len        <= '0;
      div_q      <= '0;
      wr_en      <= 1'b0;
      wr_bank    <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      drop_cnt   <= '0;
      frm_cnt    <= '0;
    end else begin
      state_q <= state_d;
      wr_en   <= do_wr;
      if (take) begin
        cur_bank <= take_bank;
        len      <= '0;
      end
      if (proc) begin
        hdr_seen <= hdr_in || rx_addr == '0;
        ovf      <= ovf_in || (hdr_in && rx_addr > MAX_A);
        if (rx_addr == '0) div_q <= rx_div;
      end
      if (do_wr) begin
        wr_bank <= cur_bank;
        wr_addr <= WAW'(rx_addr - AW'(1));
        wr_data <= rx_data;
        len     <= rx_addr;
      end
      if (push) begin
        last_bank <= cur_bank;
        frm_cnt   <= frm_cnt + 1'b1;
      end
      if ((drop_inc || (commit && !keep)) && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      // Each event fires only from a distinct source state.
      for (int b = 0; b < 2; b++) begin
        if (take && take_bank == 1'(b)) bank_st[b] <= FILLING;
        if (commit && cur_bank == 1'(b))
          bank_st[b] <= keep ? QUEUED : FREE;
        if (pop && head.bank == 1'(b)) bank_st[b] <= HELD;
        if (rel && rel_bank == 1'(b) && bank_st[b] == HELD)
          bank_st[b] <= FREE;
      end
    end
  end

  rx_desc_fifo u_fifo (
    .clk       (rxclk),
    .rst       (rst),
    .in_valid  (push),
    .in_ready  (fifo_ready),
    .in_desc   (in_desc),
    .out_valid (frm_valid),
    .out_ready (frm_ready),
    .out_desc  (head)
  );

  assign frm_bank = head.bank;
  assign frm_len  = AW'(head.len);
  assign frm_div  = head.div;

endmodule

// File: doc/rx_frame_ctrl.md
Name: rx_frame_ctrl

Overview:
Sequences frames from the RGMII byte receiver into a two-bank ping-pong frame buffer, one bank per frame. Generates buffer write strobes and addresses, and captures each frame's length and divider byte. Publishes completed frames to the downstream consumer through a valid/ready descriptor queue. Drops frames when no bank is free, or when a frame is too short or too long, and counts the drops. Sits between the receiver and the frame RAM, in the receive clock domain.

Parameters:
AW, 14, receiver byte-index width (matches receiver addr)
MAX_LEN, 4096, maximum payload bytes per bank; must be ≤ 2^(AW-1)
MIN_LEN, 1, minimum payload bytes for a frame to be kept
CW, 16, drop/accept counter width

Ports:
rxclk  in  1  receive clock; all logic on posedge
rst  in  1  synchronous active-high reset
rx_active  in  1  frame-active (receiver control line), sampled on rxclk
rx_addr  in  AW  receiver payload index: 0 = divider byte, k≥1 = payload byte k
rx_data  in  8  receiver data byte, aligned with rx_addr
rx_div  in  8  receiver divider byte
wr_en  out  1  buffer write strobe
wr_bank  out  1  bank written
wr_addr  out  $clog2(MAX_LEN)  byte address within bank (rx_addr-1)
wr_data  out  8  byte written
frm_valid  out  1  descriptor available
frm_ready  in  1  consumer accepts descriptor
frm_bank  out  1  bank holding the frame
frm_len  out  AW  payload length in bytes
frm_div  out  8  divider byte of the frame
rel  in  1  one-cycle pulse: consumer releases bank rel_bank
rel_bank  in  1  bank being released
drop_cnt  out  CW  frames dropped, saturating
frm_cnt  out  CW  frames committed, wrapping

Behaviour:
- Reset: FSM=IDLE; both banks FREE; queue empty; all outputs 0 (frm_valid=0, wr_en=0, counters 0).
- Bank states: FREE → FILLING (FSM takes it) → QUEUED (commit) → HELD (descriptor handshake) → FREE (rel). A rel for a bank that is not HELD is ignored.
- FSM states: IDLE, RECV, DROP, COMMIT.
- IDLE, rx_active=1:
  - A bank is FREE → RECV on it. With both FREE, take the bank opposite the last one used (bank 0 after reset).
  - No bank FREE → DROP.
- RECV:
  - hdr_seen is cleared on entry.
  - When rx_addr==0, capture frm_div from rx_div and set hdr_seen.
  - Before hdr_seen, all rx_addr values are ignored, including wrapped large values.
  - When hdr_seen and 1≤rx_addr≤MAX_LEN: wr_en=1 same cycle (combinational from registered inputs is not allowed; outputs are registered, so 1-cycle latency from input sample to strobe). wr_addr=rx_addr-1, wr_data=rx_data, len=rx_addr.
  - rx_addr>MAX_LEN after hdr_seen: set ovf; no further writes.
  - The cycle rx_active samples 0: that cycle's rx_addr/rx_data are still processed (last byte), then → COMMIT.
- COMMIT (1 cycle):
  - Condition: !ovf && hdr_seen && len≥MIN_LEN.
  - If met: bank → QUEUED, descriptor {bank, len, div} pushed, frm_cnt+1.
  - Otherwise: bank → FREE, drop_cnt+1.
  - Then → IDLE.
- DROP: no writes. On rx_active=0, drop_cnt+1 → IDLE.
- Queue: 2 entries, FIFO order; it never overflows (at most 2 banks). frm_valid = queue non-empty; head fields stable while frm_valid && !frm_ready. A pop on frm_valid&&frm_ready marks the bank HELD.
- Simultaneous events:
  - COMMIT push and pop in the same cycle: both apply.
  - rel in the same cycle as IDLE bank selection: the bank does not count as FREE until the next cycle.
- drop_cnt saturates at all-ones; frm_cnt wraps.
- Reset mid-frame: returns to IDLE; the rest of the frame is treated as a new frame only if rx_active is still high (it will lack hdr_seen and be dropped at COMMIT).

Decomposition:
- Package rx_frame_pkg: bank_state_t enum (FREE, FILLING, QUEUED, HELD), fsm_t enum, descriptor struct {bank, len, div}.
- Sub-module: rx_desc_fifo, a 2-deep descriptor FIFO with valid/ready.

Test Plan:
- Single frame, rx_addr 0..100 with div=0x5A, frm_ready=1 → 100 writes to bank 0, wr_addr 0..99; descriptor {0,100,0x5A}; frm_cnt=1.
- Two back-to-back frames of 64 bytes, frm_ready=0 → banks 0 and 1 both QUEUED. A third frame is dropped → drop_cnt=1, wr_en never asserted during it.
- Oversize frame with MAX_LEN=4096, rx_addr reaching 4100 → writes stop after wr_addr 4095; drop_cnt+1; bank 0 FREE again.
- Frame that ends before rx_addr reaches 0 (no header) → no writes, drop_cnt+1, no descriptor.
- Handshake and release: descriptor popped, then rel=1 with rel_bank=0 → bank 0 reused by the next frame. A rel to a FREE bank has no effect.
- rst asserted mid-frame at rx_addr=30 → outputs zero the next cycle; queue empty; following good frame lands in bank 0.
